// File: rtl/spi_tx_queue_if.sv
// Host-side and SPI-master-side signal bundle for the transmit byte queue.
// The slave modport is the queue itself; the master modport is whatever drives it.
interface spi_tx_queue_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic [7:0]    spi_data;
  logic          spi_rdy;
  logic          xfer_done;
  logic [7:0]    rx_in;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ack;
  logic          rx_overrun;
  logic          busy;

  modport slave (
    input  wr_en, wr_data, xfer_done, rx_in, rx_ack,
    output full, empty, count, spi_data, spi_rdy,
           rx_data, rx_valid, rx_overrun, busy
  );

  modport master (
    output wr_en, wr_data, xfer_done, rx_in, rx_ack,
    input  full, empty, count, spi_data, spi_rdy,
           rx_data, rx_valid, rx_overrun, busy
  );
endinterface

// File: rtl/spi_tx_queue.sv
// Byte FIFO feeding an SPI master one byte at a time, popping on each end-of-byte
// pulse and capturing the master's receive byte into a host holding register.
module spi_tx_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         clk,
  input  logic         rst,
  spi_tx_queue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t        state, state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, load_ptr;
  logic [AW:0]   count, count_next;
  logic [7:0]    spi_data, rx_data;
  logic          spi_rdy, rdy_next;
  logic          rx_valid, rx_overrun, busy;
  logic          load_en, push, pop, full, empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.wr_en && !full;
  assign pop   = (state == SHIFT) && bus.xfer_done;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    load_ptr   = rd_ptr;
    rdy_next   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = LOAD;
          load_en    = 1'b1;
        end
      end
      LOAD: begin
        state_next = SHIFT;
        rdy_next   = 1'b1;
      end
      SHIFT: begin
        rdy_next = 1'b1;
        if (bus.xfer_done) begin
          rdy_next = 1'b0;
          // Only bytes already stored count here; a same-cycle write is not
          // yet readable, so it is picked up from IDLE on the next cycle.
          if (count > (AW+1)'(1)) begin
            state_next = LOAD;
            load_en    = 1'b1;
            load_ptr   = rd_ptr + AW'(1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_data <= 8'h00;
      spi_rdy  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      spi_rdy <= rdy_next;
      busy    <= (state_next != IDLE);
      if (load_en) spi_data <= mem[load_ptr];
    end
  end

  // A capture always beats a simultaneous acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (pop) begin
      rx_data  <= bus.rx_in;
      rx_valid <= 1'b1;
      if (rx_valid && !bus.rx_ack) rx_overrun <= 1'b1;
    end else if (bus.rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.count      = count;
  assign bus.spi_data   = spi_data;
  assign bus.spi_rdy    = spi_rdy;
  assign bus.rx_data    = rx_data;
  assign bus.rx_valid   = rx_valid;
  assign bus.rx_overrun = rx_overrun;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_spi_tx_queue.sv
// Directed bench for spi_tx_queue: a byte scoreboard checks transmit order as
// each byte is offered to the master, and a small receive model tracks rx flags.
module tb_spi_tx_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_tx_queue_if #(.DEPTH(8), .AW(3)) bus ();

  spi_tx_queue #(.DEPTH(8), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          mcount = 0;
  logic [7:0]  mrx    = 8'h00;
  logic        mvalid = 1'b0;
  logic        movr   = 1'b0;
  logic        rdy_prev = 1'b0;
  logic [7:0]  held     = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en   = 1'b0;
    if (mcount < 8) begin
      exp_q.push_back(b);
      mcount++;
    end
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!bus.spi_rdy && n < 50) begin
      tick();
      n++;
    end
    check("wait_rdy", bus.spi_rdy, 1);
  endtask

  task automatic rx_model(input logic [7:0] rx, input logic ack);
    if (mvalid && !ack) movr = 1'b1;
    mvalid = 1'b1;
    mrx    = rx;
  endtask

  task automatic xfer(input logic [7:0] rx, input logic ack);
    wait_rdy();
    bus.xfer_done = 1'b1;
    bus.rx_in     = rx;
    bus.rx_ack    = ack;
    tick();
    bus.xfer_done = 1'b0;
    bus.rx_ack    = 1'b0;
    mcount--;
    rx_model(rx, ack);
    check("rx_data", bus.rx_data, mrx);
    check("rx_valid", bus.rx_valid, mvalid);
    check("rx_overrun", bus.rx_overrun, movr);
    check("rdy_drop", bus.spi_rdy, 0);
  endtask

  task automatic ack_rx();
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
    mvalid = 1'b0;
    check("rx_ack_clear", bus.rx_valid, 0);
  endtask

  // Scoreboard: every new offer to the master must be the oldest queued byte.
  always @(negedge clk) begin
    if (rst) begin
      rdy_prev <= 1'b0;
    end else begin
      if (bus.spi_rdy && !rdy_prev) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", bus.spi_data, 32'hFFFF_FFFF);
        end else begin
          check("sb_order", bus.spi_data, exp_q.pop_front());
        end
        held <= bus.spi_data;
      end else if (bus.spi_rdy && rdy_prev) begin
        check("sb_stable", bus.spi_data, held);
      end
      rdy_prev <= bus.spi_rdy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en     = 1'b0;
    bus.wr_data   = 8'h00;
    bus.xfer_done = 1'b0;
    bus.rx_in     = 8'h00;
    bus.rx_ack    = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_spi_rdy", bus.spi_rdy, 0);
    check("rst_spi_data", bus.spi_data, 8'h00);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_overrun", bus.rx_overrun, 0);
    check("rst_busy", bus.busy, 0);

    // Single byte latency
    write_byte(8'hB4);
    check("sb_count1", bus.count, 1);
    check("sb_rdy_n", bus.spi_rdy, 0);
    tick();
    check("sb_data_n1", bus.spi_data, 8'hB4);
    check("sb_rdy_n1", bus.spi_rdy, 0);
    check("sb_busy_n1", bus.busy, 1);
    tick();
    check("sb_rdy_n2", bus.spi_rdy, 1);
    repeat (17) tick();
    check("sb_rdy_hold", bus.spi_rdy, 1);
    xfer(8'h97, 1'b0);
    check("sb_busy_end", bus.busy, 0);
    check("sb_count_end", bus.count, 0);
    ack_rx();

    // Burst with one-cycle delimiter between bytes
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      xfer(8'h40 + 8'(i), 1'b1);
      if (i < 2) begin
        check("burst_load_data", bus.spi_data, 8'(i + 2));
        tick();
        check("burst_rdy_back", bus.spi_rdy, 1);
      end
    end
    check("burst_count", bus.count, 0);
    check("burst_empty", bus.empty, 1);
    ack_rx();

    // Fill past full, then drain and refill across the pointer wrap
    for (int i = 0; i < 9; i++) write_byte(8'h10 + 8'(i));
    check("full_flag", bus.full, 1);
    check("full_count", bus.count, 8);
    check("full_not_empty", bus.empty, 0);
    for (int i = 0; i < 8; i++) xfer(8'h60 + 8'(i), 1'b1);
    check("drain_empty", bus.empty, 1);
    for (int i = 0; i < 8; i++) write_byte(8'h20 + 8'(i));
    check("refill_full", bus.full, 1);
    for (int i = 0; i < 8; i++) xfer(8'h70 + 8'(i), 1'b1);
    check("refill_count", bus.count, 0);
    ack_rx();

    // Accepted write and pop in the same cycle
    write_byte(8'hA0);
    write_byte(8'hA1);
    write_byte(8'hA2);
    wait_rdy();
    check("sim_count_pre", bus.count, 3);
    bus.wr_en     = 1'b1;
    bus.wr_data   = 8'hA3;
    bus.xfer_done = 1'b1;
    bus.rx_in     = 8'h5A;
    bus.rx_ack    = 1'b1;
    tick();
    bus.wr_en     = 1'b0;
    bus.xfer_done = 1'b0;
    bus.rx_ack    = 1'b0;
    exp_q.push_back(8'hA3);
    rx_model(8'h5A, 1'b1);
    check("sim_count_post", bus.count, 3);
    check("sim_rx_valid", bus.rx_valid, 1);
    check("sim_rx_data", bus.rx_data, 8'h5A);
    check("sim_overrun", bus.rx_overrun, 0);
    for (int i = 0; i < 3; i++) xfer(8'h80 + 8'(i), 1'b1);
    check("sim_empty", bus.empty, 1);
    ack_rx();

    // Overrun is sticky until reset
    write_byte(8'hC1);
    write_byte(8'hC2);
    xfer(8'hAA, 1'b0);
    xfer(8'h55, 1'b0);
    check("ovr_data", bus.rx_data, 8'h55);
    check("ovr_flag", bus.rx_overrun, 1);
    ack_rx();
    repeat (3) tick();
    check("ovr_sticky", bus.rx_overrun, 1);

    // Asynchronous reset in the middle of a shift
    write_byte(8'hD0);
    write_byte(8'hD1);
    write_byte(8'hD2);
    wait_rdy();
    #2;
    rst = 1'b1;
    #1;
    check("arst_rdy", bus.spi_rdy, 0);
    check("arst_count", bus.count, 0);
    check("arst_overrun", bus.rx_overrun, 0);
    check("arst_busy", bus.busy, 0);
    exp_q.delete();
    mcount = 0;
    mvalid = 1'b0;
    movr   = 1'b0;
    mrx    = 8'h00;
    tick();
    rst = 1'b0;
    tick();
    check("arst_count_hold", bus.count, 0);
    write_byte(8'hE5);
    check("restart_count", bus.count, 1);
    tick();
    check("restart_data", bus.spi_data, 8'hE5);
    xfer(8'h3C, 1'b0);
    check("restart_empty", bus.empty, 1);
    tick();
    check("sb_leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
